// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares the single Common Data Bus between NUM_UNITS execution units.
//   - Each unit holds its result (valid/tag/data) until it sees its ack.
//   - One unit is granted per cycle, chosen round-robin.
//   - The winner is broadcast on a registered CDB one cycle after its ack.
//   - The registered CDB feeds the RS, ROB and regfile tag match.
//
// Ports:
//   clk        in   1                      clock, rising edge
//   rst_n      in   1                      asynchronous, active-low reset
//   req_valid  in   NUM_UNITS              unit i has a result pending
//   req_tag    in   NUM_UNITS*TAG_WIDTH    unit i tag at [i*TAG_WIDTH +: TAG_WIDTH]
//   req_data   in   NUM_UNITS*DATA_WIDTH   unit i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack    out  NUM_UNITS              one-hot grant, combinational
//   cdb_stall  in   1                      consumer cannot take a broadcast now
//   cdb_flush  in   1                      pipeline flush, kills the next broadcast
//   cdb_valid  out  1                      broadcast valid (registered)
//   cdb_tag    out  TAG_WIDTH              broadcast tag
//   cdb_data   out  DATA_WIDTH             broadcast data
//   cdb_src    out  $clog2(NUM_UNITS)      index of the unit that produced it
//   busy       out  1                      any request pending or broadcast valid
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_UNITS-1:0]             req_valid,
    input  logic [NUM_UNITS*TAG_WIDTH-1:0]   req_tag,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_UNITS-1:0]             req_ack,
    input  logic                             cdb_stall,
    input  logic                             cdb_flush,
    output logic                             cdb_valid,
    output logic [TAG_WIDTH-1:0]             cdb_tag,
    output logic [DATA_WIDTH-1:0]            cdb_data,
    output logic [$clog2(NUM_UNITS)-1:0]     cdb_src,
    output logic                             busy
);

    localparam int                PTR_W    = $clog2(NUM_UNITS);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_UNITS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]      r_rr_ptr;
    logic                  r_cdb_valid;
    logic [TAG_WIDTH-1:0]  r_cdb_tag;
    logic [DATA_WIDTH-1:0] r_cdb_data;
    logic [PTR_W-1:0]      r_cdb_src;

    // -------------------------------------------------------------------------
    // Arbitration wires
    // -------------------------------------------------------------------------
    logic                  w_grant_en;
    logic [NUM_UNITS-1:0]  w_hi_mask;
    logic [NUM_UNITS-1:0]  w_req_hi;
    logic [NUM_UNITS-1:0]  w_onehot_hi;
    logic [NUM_UNITS-1:0]  w_onehot_all;
    logic [NUM_UNITS-1:0]  w_onehot;
    logic [NUM_UNITS-1:0]  w_ack;
    logic                  w_grant_valid;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [TAG_WIDTH-1:0]  w_grant_tag;
    logic [DATA_WIDTH-1:0] w_grant_data;
    logic [PTR_W-1:0]      w_next_ptr;

    logic [TAG_WIDTH-1:0]  w_tag_arr  [NUM_UNITS];
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_UNITS];

    // Acks are forced low while reset is held, and flush/stall block any grant.
    // Only inputs and r_rr_ptr feed this path, never the cdb_* registers, so
    // there is no flop-free loop from the broadcast back into the grant.
    assign w_grant_en = rst_n & ~cdb_stall & ~cdb_flush;

    // Split the packed request buses and build the "at or above rr_ptr" mask.
    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            assign w_tag_arr[gi]  = req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
            assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_hi_mask[gi]  = (PTR_W'(gi) >= r_rr_ptr);
        end
    endgenerate

    assign w_req_hi = req_valid & w_hi_mask;

    // Two lowest-index-first priority encoders: one over requests at or above
    // the pointer, one over all requests. If anything sits at or above the
    // pointer it wins; otherwise the search has wrapped to the bottom.
    always_comb begin
        logic seen_hi;
        logic seen_all;
        w_onehot_hi  = '0;
        w_onehot_all = '0;
        seen_hi      = 1'b0;
        seen_all     = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_req_hi[i] && !seen_hi) begin
                w_onehot_hi[i] = 1'b1;
                seen_hi        = 1'b1;
            end
            if (req_valid[i] && !seen_all) begin
                w_onehot_all[i] = 1'b1;
                seen_all        = 1'b1;
            end
        end
    end

    assign w_onehot      = (|w_req_hi) ? w_onehot_hi : w_onehot_all;
    assign w_ack         = w_grant_en ? w_onehot : '0;
    assign w_grant_valid = |w_ack;

    // One-hot to index plus AND-OR mux of the winning tag/data.
    always_comb begin
        w_grant_idx  = '0;
        w_grant_tag  = '0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_onehot[i]) begin
                w_grant_idx  = w_grant_idx | PTR_W'(i);
                w_grant_tag  = w_grant_tag | w_tag_arr[i];
                w_grant_data = w_grant_data | w_data_arr[i];
            end
        end
    end

    // Pointer moves to just past the winner so the winner becomes lowest priority.
    assign w_next_ptr = (w_grant_idx == LAST_IDX) ? '0 : (w_grant_idx + 1'b1);

    // -------------------------------------------------------------------------
    // Registered CDB and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else if (w_grant_valid) begin
            r_rr_ptr    <= w_next_ptr;
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= w_grant_tag;
            r_cdb_data  <= w_grant_data;
            r_cdb_src   <= w_grant_idx;
        end else begin
            // Broadcast is a single-cycle pulse; payload and pointer hold.
            r_cdb_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ack   = w_ack;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;
    assign busy      = (|req_valid) | r_cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Purpose:
//   Directed bench for cdb_arbiter with 4 units, 6-bit tags and 32-bit data.
//   - Inputs change 1 time unit after a rising edge.
//   - Combinational acks are sampled 1 unit after that.
//   - Registered CDB outputs are sampled 1 unit after the following edge.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ack;
    logic              cdb_stall;
    logic              cdb_flush;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [1:0]        cdb_src;
    logic              busy;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(
        .NUM_UNITS  (N),
        .TAG_WIDTH  (TW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .cdb_stall (cdb_stall),
        .cdb_flush (cdb_flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        req_tag[i*TW +: TW] = t;
        req_data[i*DW +: DW] = d;
    endtask

    // Check the registered broadcast.
    task automatic check_cdb(input string tag, input logic v, input logic [TW-1:0] t,
                             input logic [DW-1:0] d, input logic [1:0] s);
        check({tag, ".valid"}, {31'd0, cdb_valid}, {31'd0, v});
        check({tag, ".tag"},   {26'd0, cdb_tag},   {26'd0, t});
        check({tag, ".data"},  cdb_data,           d);
        check({tag, ".src"},   {30'd0, cdb_src},   {30'd0, s});
    endtask

    task automatic check_ack(input string tag, input logic [N-1:0] exp);
        #1;
        check(tag, {28'd0, req_ack}, {28'd0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        cdb_stall = 1'b0;
        cdb_flush = 1'b0;

        // ---------------- Reset state ----------------
        tick();
        check_cdb("reset", 1'b0, 6'd0, 32'd0, 2'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        req_valid = 4'b1111;
        check_ack("reset.ack_gated", 4'b0000);
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b1;

        // ---------------- 1: single request from unit 0 ----------------
        set_unit(0, 6'd5, 32'hA5);
        req_valid = 4'b0001;
        check_ack("t1.ack", 4'b0001);
        tick();
        check_cdb("t1.cdb", 1'b1, 6'd5, 32'hA5, 2'd0);
        check("t1.busy", {31'd0, busy}, 32'd1);
        req_valid = 4'b0000;
        check_ack("t1.ack_idle", 4'b0000);
        tick();
        check_cdb("t1.pulse_end", 1'b0, 6'd5, 32'hA5, 2'd0);
        check("t1.busy_idle", {31'd0, busy}, 32'd0);

        // ---------------- 2: all four request continuously ----------------
        do_reset();
        for (int i = 0; i < N; i++) set_unit(i, TW'(10 + i), 32'h100 + i);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            check_ack($sformatf("t2.ack%0d", k), 4'b0001 << (k % 4));
            tick();
            check_cdb($sformatf("t2.cdb%0d", k), 1'b1, TW'(10 + (k % 4)),
                      32'h100 + (k % 4), 2'(k % 4));
        end
        req_valid = 4'b0000;
        tick();
        // rr_ptr is now 1 (last grant went to unit 0).

        // ---------------- 3: wrap from rr_ptr=3 ----------------
        req_valid = 4'b0100;                  // grant unit 2 -> rr_ptr=3
        check_ack("t3.setup_ack", 4'b0100);
        tick();
        req_valid = 4'b1001;
        check_ack("t3.ack3", 4'b1000);
        tick();
        check_cdb("t3.cdb3", 1'b1, 6'd13, 32'h103, 2'd3);
        req_valid = 4'b0001;                  // unit 3 dropped after its ack
        check_ack("t3.ack0", 4'b0001);
        tick();
        check_cdb("t3.cdb0", 1'b1, 6'd10, 32'h100, 2'd0);
        req_valid = 4'b0011;                  // rr_ptr=1 -> unit 1 beats unit 0
        check_ack("t3.ptr1", 4'b0010);
        tick();
        // rr_ptr is now 2.

        // ---------------- 4: stall for 3 cycles ----------------
        req_valid = 4'b0110;
        cdb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_ack($sformatf("t4.stall_ack%0d", k), 4'b0000);
            tick();
            check($sformatf("t4.stall_valid%0d", k), {31'd0, cdb_valid}, 32'd0);
        end
        cdb_stall = 1'b0;
        check_ack("t4.rel_ack2", 4'b0100);
        tick();
        check_cdb("t4.cdb2", 1'b1, 6'd12, 32'h102, 2'd2);
        req_valid = 4'b0010;
        check_ack("t4.rel_ack1", 4'b0010);
        tick();
        check_cdb("t4.cdb1", 1'b1, 6'd11, 32'h101, 2'd1);
        // rr_ptr is now 2.

        // ---------------- 5: grant then flush ----------------
        req_valid = 4'b0100;
        check_ack("t5.ackN", 4'b0100);
        tick();
        req_valid = 4'b1010;
        cdb_flush = 1'b1;
        cdb_stall = 1'b1;
        check_cdb("t5.cdbN1", 1'b1, 6'd12, 32'h102, 2'd2);
        check_ack("t5.ackN1", 4'b0000);
        tick();
        check("t5.validN2", {31'd0, cdb_valid}, 32'd0);
        cdb_flush = 1'b0;
        cdb_stall = 1'b0;
        req_valid = 4'b1011;                  // rr_ptr held at 3 through flush
        check_ack("t5.after_flush", 4'b1000);
        tick();
        check_cdb("t5.cdb3", 1'b1, 6'd13, 32'h103, 2'd3);
        req_valid = 4'b0011;
        check_ack("t5.ack0", 4'b0001);
        tick();
        // rr_ptr is now 1, cdb_valid=1.

        // ---------------- 6: async reset mid-operation ----------------
        req_valid = 4'b1111;
        check("t6.pre_valid", {31'd0, cdb_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_cdb("t6.async", 1'b0, 6'd0, 32'd0, 2'd0);
        check("t6.ack_in_reset", {28'd0, req_ack}, 32'd0);
        tick();
        rst_n = 1'b1;
        check_ack("t6.unit0_first", 4'b0001);
        tick();
        check_cdb("t6.cdb0", 1'b1, 6'd10, 32'h100, 2'd0);
        req_valid = 4'b0000;
        tick();
        check("t6.busy_end", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
